// File: rtl/io_request_arbiter_if.sv
// Request/IO bus bundle for io_request_arbiter.
// master: the arbiter (answers both requesters, drives the IO request bus).
// slave:  the environment (two requesters plus the peripheral IO side).
interface io_request_arbiter_if #(
  parameter int P_ADDR_W = 32,
  parameter int P_DATA_W = 32
);
  logic                iREQ0_REQ;
  logic                oREQ0_BUSY;
  logic [1:0]          iREQ0_ORDER;
  logic                iREQ0_RW;
  logic [P_ADDR_W-1:0] iREQ0_ADDR;
  logic [P_DATA_W-1:0] iREQ0_DATA;
  logic                oREQ0_VALID;
  logic                oREQ0_ERROR;
  logic [P_DATA_W-1:0] oREQ0_DATA;

  logic                iREQ1_REQ;
  logic                oREQ1_BUSY;
  logic [1:0]          iREQ1_ORDER;
  logic                iREQ1_RW;
  logic [P_ADDR_W-1:0] iREQ1_ADDR;
  logic [P_DATA_W-1:0] iREQ1_DATA;
  logic                oREQ1_VALID;
  logic                oREQ1_ERROR;
  logic [P_DATA_W-1:0] oREQ1_DATA;

  logic                oIO_REQ;
  logic                iIO_BUSY;
  logic [1:0]          oIO_ORDER;
  logic                oIO_RW;
  logic [P_ADDR_W-1:0] oIO_ADDR;
  logic [P_DATA_W-1:0] oIO_DATA;
  logic                iIO_VALID;
  logic [P_DATA_W-1:0] iIO_DATA;

  modport master (
    input  iREQ0_REQ, iREQ0_ORDER, iREQ0_RW, iREQ0_ADDR, iREQ0_DATA,
    output oREQ0_BUSY, oREQ0_VALID, oREQ0_ERROR, oREQ0_DATA,
    input  iREQ1_REQ, iREQ1_ORDER, iREQ1_RW, iREQ1_ADDR, iREQ1_DATA,
    output oREQ1_BUSY, oREQ1_VALID, oREQ1_ERROR, oREQ1_DATA,
    output oIO_REQ, oIO_ORDER, oIO_RW, oIO_ADDR, oIO_DATA,
    input  iIO_BUSY, iIO_VALID, iIO_DATA
  );

  modport slave (
    output iREQ0_REQ, iREQ0_ORDER, iREQ0_RW, iREQ0_ADDR, iREQ0_DATA,
    input  oREQ0_BUSY, oREQ0_VALID, oREQ0_ERROR, oREQ0_DATA,
    output iREQ1_REQ, iREQ1_ORDER, iREQ1_RW, iREQ1_ADDR, iREQ1_DATA,
    input  oREQ1_BUSY, oREQ1_VALID, oREQ1_ERROR, oREQ1_DATA,
    input  oIO_REQ, oIO_ORDER, oIO_RW, oIO_ADDR, oIO_DATA,
    output iIO_BUSY, iIO_VALID, iIO_DATA
  );
endinterface

// File: rtl/io_request_arbiter.sv
// Two-requester round-robin arbiter onto a single IO request bus.
// One transaction in flight; write ack is generated locally, read data is
// routed back to its owner, and a read with no return is aborted with error.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | arbitrating; the granted requester sees BUSY low
//   S_ISSUE   | oIO_REQ held until the IO side takes it (idle slot if illegal)
//   S_WAIT_RD | read issued, counting towards the timeout
//   S_RESP    | one-cycle completion pulse to the owner
module io_request_arbiter #(
  parameter int P_ADDR_W  = 32,
  parameter int P_DATA_W  = 32,
  parameter int P_TIMEOUT = 255
) (
  input logic                  iCLOCK,
  input logic                  iRESET,
  io_request_arbiter_if.master bus
);
  localparam int               CNT_W      = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(P_TIMEOUT - 1);
  localparam logic [1:0]       ORDER_NONE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                grant_vld, grant_id;
  logic                owner_q, ptr_q;
  logic [1:0]          order_q;
  logic                rw_q;
  logic [P_ADDR_W-1:0] addr_q;
  logic [P_DATA_W-1:0] wdata_q;
  logic                io_req_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                resp_valid_q, resp_err_q;
  logic [P_DATA_W-1:0] resp_data_q;
  logic                io_xfer;

  logic [1:0]          sel_order;
  logic                sel_rw;
  logic [P_ADDR_W-1:0] sel_addr;
  logic [P_DATA_W-1:0] sel_data;

  assign io_xfer   = io_req_q && !bus.iIO_BUSY;
  assign sel_order = grant_id ? bus.iREQ1_ORDER : bus.iREQ0_ORDER;
  assign sel_rw    = grant_id ? bus.iREQ1_RW    : bus.iREQ0_RW;
  assign sel_addr  = grant_id ? bus.iREQ1_ADDR  : bus.iREQ0_ADDR;
  assign sel_data  = grant_id ? bus.iREQ1_DATA  : bus.iREQ0_DATA;

  // Round-robin pick in IDLE: a lone requester wins, a tie goes away from the last owner.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.iREQ0_REQ && bus.iREQ1_REQ) begin
        grant_vld = 1'b1;
        grant_id  = ~ptr_q;
      end else if (bus.iREQ0_REQ) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.iREQ1_REQ) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  // BUSY is low only for the requester being granted this cycle; never while in reset.
  assign bus.oREQ0_BUSY = iRESET || !(grant_vld && !grant_id);
  assign bus.oREQ1_BUSY = iRESET || !(grant_vld &&  grant_id);

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (grant_vld) state_d = S_ISSUE;
      S_ISSUE: begin
        // An illegal order burns its issue slot without touching the IO bus,
        // so the error completes with the same latency as a write.
        if (order_q == ORDER_NONE) state_d = S_RESP;
        else if (io_xfer)          state_d = rw_q ? S_RESP : S_WAIT_RD;
      end
      S_WAIT_RD: if (bus.iIO_VALID || cnt_q == CNT_LAST) state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request latch, IO handshake, timeout counter and response capture.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      owner_q      <= 1'b0;
      ptr_q        <= 1'b1;
      order_q      <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      io_req_q     <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= (state_d == S_RESP);
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            owner_q  <= grant_id;
            ptr_q    <= grant_id;
            order_q  <= sel_order;
            rw_q     <= sel_rw;
            addr_q   <= sel_addr;
            wdata_q  <= sel_data;
            io_req_q <= (sel_order != ORDER_NONE);
          end
        end
        S_ISSUE: begin
          if (order_q == ORDER_NONE) begin
            resp_err_q  <= 1'b1;
            resp_data_q <= '0;
          end else if (io_xfer) begin
            io_req_q    <= 1'b0;
            cnt_q       <= '0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
          end
        end
        S_WAIT_RD: begin
          if (bus.iIO_VALID) begin
            resp_err_q  <= 1'b0;
            resp_data_q <= bus.iIO_DATA;
          end else if (cnt_q == CNT_LAST) begin
            resp_err_q  <= 1'b1;
            resp_data_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.oIO_REQ   = io_req_q;
  assign bus.oIO_ORDER = order_q;
  assign bus.oIO_RW    = rw_q;
  assign bus.oIO_ADDR  = addr_q;
  assign bus.oIO_DATA  = wdata_q;

  assign bus.oREQ0_VALID = resp_valid_q && !owner_q;
  assign bus.oREQ0_ERROR = resp_valid_q && !owner_q && resp_err_q;
  assign bus.oREQ0_DATA  = (resp_valid_q && !owner_q) ? resp_data_q : '0;
  assign bus.oREQ1_VALID = resp_valid_q && owner_q;
  assign bus.oREQ1_ERROR = resp_valid_q && owner_q && resp_err_q;
  assign bus.oREQ1_DATA  = (resp_valid_q && owner_q) ? resp_data_q : '0;
endmodule

// File: tb/tb_io_request_arbiter.sv
// Bench for io_request_arbiter: directed scenarios plus a response scoreboard.
module tb_io_request_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  io_request_arbiter_if #(.P_ADDR_W(AW), .P_DATA_W(DW)) bus ();

  io_request_arbiter #(.P_ADDR_W(AW), .P_DATA_W(DW), .P_TIMEOUT(TMO)) dut (
    .iCLOCK (clk),
    .iRESET (rst),
    .bus    (bus)
  );

  typedef struct {
    bit            id;
    bit            err;
    logic [DW-1:0] data;
  } resp_t;

  resp_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    last_grant = 1'b1;

  logic          m_v, m_e;
  logic [DW-1:0] m_d;
  resp_t         m_x;

  task automatic push_exp(input bit id, input bit err, input logic [DW-1:0] data);
    resp_t r;
    r.id = id; r.err = err; r.data = data;
    sb.push_back(r);
  endtask

  // Scoreboard: every completion pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      for (int n = 0; n < 2; n++) begin
        m_v = (n == 1) ? bus.oREQ1_VALID : bus.oREQ0_VALID;
        m_e = (n == 1) ? bus.oREQ1_ERROR : bus.oREQ0_ERROR;
        m_d = (n == 1) ? bus.oREQ1_DATA  : bus.oREQ0_DATA;
        n_checks++;
        if (m_v === 1'b1) begin
          if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: requester %0d VALID err=%0b data=%h, none expected", n, m_e, m_d);
          end else begin
            m_x = sb.pop_front();
            if (m_x.id !== 1'(n) || m_x.err !== m_e || m_x.data !== m_d)
              $display("FAIL sb_resp: got req %0d err=%0b data=%h, expected req %0d err=%0b data=%h",
                       n, m_e, m_d, m_x.id, m_x.err, m_x.data);
            else n_pass++;
          end
        end else if (m_v !== 1'b0 || m_e !== 1'b0 || m_d !== '0) begin
          $display("FAIL quiet_outputs: req %0d valid=%b err=%b data=%h, expected 0/0/0", n, m_v, m_e, m_d);
        end else n_pass++;
      end
    end
  end

  task automatic wait_grant(output int id, output bit ok);
    id = -1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus.oREQ0_BUSY === 1'b0 && bus.oREQ1_BUSY === 1'b0) begin
        n_checks++;
        $display("FAIL grant_exclusive: both BUSY low, expected at most one");
      end
      if (bus.oREQ0_BUSY === 1'b0) begin id = 0; ok = 1'b1; end
      else if (bus.oREQ1_BUSY === 1'b0) begin id = 1; ok = 1'b1; end
      if (ok) begin
        last_grant = id[0];
        @(posedge clk);
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL grant_timeout: no grant within 20 cycles, expected one");
    end
  endtask

  // Call just after a negedge; returns at the negedge of the cycle after acceptance.
  task automatic do_request(input int n, input logic [1:0] order, input bit rw,
                            input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int id;
    bit ok;
    if (n == 0) begin
      bus.iREQ0_ORDER = order; bus.iREQ0_RW = rw; bus.iREQ0_ADDR = addr; bus.iREQ0_DATA = data;
      bus.iREQ0_REQ = 1'b1;
    end else begin
      bus.iREQ1_ORDER = order; bus.iREQ1_RW = rw; bus.iREQ1_ADDR = addr; bus.iREQ1_DATA = data;
      bus.iREQ1_REQ = 1'b1;
    end
    wait_grant(id, ok);
    if (ok) begin
      n_checks++;
      if (id !== n) $display("FAIL grant_owner: granted %0d, expected %0d", id, n);
      else n_pass++;
    end
    if (n == 0) bus.iREQ0_REQ = 1'b0;
    else        bus.iREQ1_REQ = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iREQ0_REQ = 0; bus.iREQ0_ORDER = 0; bus.iREQ0_RW = 0; bus.iREQ0_ADDR = 0; bus.iREQ0_DATA = 0;
    bus.iREQ1_REQ = 0; bus.iREQ1_ORDER = 0; bus.iREQ1_RW = 0; bus.iREQ1_ADDR = 0; bus.iREQ1_DATA = 0;
    bus.iIO_BUSY = 0; bus.iIO_VALID = 0; bus.iIO_DATA = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.oIO_REQ, bus.oIO_ORDER, bus.oIO_RW, bus.oIO_ADDR, bus.oIO_DATA} !== '0)
      $display("FAIL reset_io: req=%b order=%b rw=%b addr=%h data=%h, expected all 0",
               bus.oIO_REQ, bus.oIO_ORDER, bus.oIO_RW, bus.oIO_ADDR, bus.oIO_DATA);
    else n_pass++;
    n_checks++;
    if ({bus.oREQ0_VALID, bus.oREQ0_ERROR, bus.oREQ0_DATA, bus.oREQ1_VALID, bus.oREQ1_ERROR, bus.oREQ1_DATA} !== '0)
      $display("FAIL reset_req: v0=%b e0=%b d0=%h v1=%b e1=%b d1=%h, expected all 0",
               bus.oREQ0_VALID, bus.oREQ0_ERROR, bus.oREQ0_DATA, bus.oREQ1_VALID, bus.oREQ1_ERROR, bus.oREQ1_DATA);
    else n_pass++;
    rst = 1'b0;
    last_grant = 1'b1;
  endtask

  task automatic test_write_basic();
    push_exp(1'b0, 1'b0, '0);
    do_request(0, 2'b10, 1'b1, 32'h100, 32'hA5);
    n_checks++;
    if ({bus.oIO_REQ, bus.oIO_ORDER, bus.oIO_RW, bus.oIO_ADDR, bus.oIO_DATA} !== {1'b1, 2'b10, 1'b1, 32'h100, 32'hA5})
      $display("FAIL wr_issue: req=%b order=%b rw=%b addr=%h data=%h, expected 1/10/1/100/a5",
               bus.oIO_REQ, bus.oIO_ORDER, bus.oIO_RW, bus.oIO_ADDR, bus.oIO_DATA);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.oIO_REQ !== 1'b0 || bus.oREQ0_VALID !== 1'b1)
      $display("FAIL wr_ack_timing: io_req=%b valid0=%b, expected 0/1", bus.oIO_REQ, bus.oREQ0_VALID);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.oREQ0_VALID !== 1'b0) $display("FAIL wr_ack_pulse: valid0=%b, expected 0", bus.oREQ0_VALID);
    else n_pass++;
  endtask

  task automatic test_io_stall();
    bus.iIO_BUSY = 1'b1;
    push_exp(1'b1, 1'b0, 32'h33);
    do_request(1, 2'b01, 1'b0, 32'h400, 32'h0);
    bus.iREQ0_ORDER = 2'b10; bus.iREQ0_RW = 1'b0; bus.iREQ0_ADDR = 32'h444; bus.iREQ0_REQ = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if ({bus.oIO_REQ, bus.oIO_ORDER, bus.oIO_RW, bus.oIO_ADDR} !== {1'b1, 2'b01, 1'b0, 32'h400} ||
          bus.oREQ0_BUSY !== 1'b1 || bus.oREQ1_BUSY !== 1'b1)
        $display("FAIL stall_hold c%0d: req=%b order=%b rw=%b addr=%h busy0=%b busy1=%b, expected 1/01/0/400/1/1",
                 c, bus.oIO_REQ, bus.oIO_ORDER, bus.oIO_RW, bus.oIO_ADDR, bus.oREQ0_BUSY, bus.oREQ1_BUSY);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.oIO_REQ !== 1'b1) $display("FAIL stall_sixth: io_req=%b, expected 1", bus.oIO_REQ);
    else n_pass++;
    bus.iIO_BUSY  = 1'b0;
    bus.iREQ0_REQ = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.oIO_REQ !== 1'b0) $display("FAIL stall_release: io_req=%b, expected 0", bus.oIO_REQ);
    else n_pass++;
    bus.iIO_VALID = 1'b1; bus.iIO_DATA = 32'h33;
    @(negedge clk);
    bus.iIO_VALID = 1'b0; bus.iIO_DATA = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    push_exp(1'b0, 1'b1, '0);
    do_request(0, 2'b10, 1'b0, 32'h500, 32'h0);
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      if (bus.oREQ0_VALID !== 1'b0) early++;
    end
    n_checks++;
    if (early != 0) $display("FAIL tmo_early: %0d early VALID cycles, expected 0", early);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.oREQ0_VALID !== 1'b1 || bus.oREQ0_ERROR !== 1'b1)
      $display("FAIL tmo_error: valid0=%b err0=%b, expected 1/1", bus.oREQ0_VALID, bus.oREQ0_ERROR);
    else n_pass++;
    @(negedge clk);
    bus.iIO_VALID = 1'b1; bus.iIO_DATA = 32'hDEAD;
    repeat (2) @(negedge clk);
    bus.iIO_VALID = 1'b0; bus.iIO_DATA = 32'h0;
    push_exp(1'b1, 1'b0, '0);
    do_request(1, 2'b00, 1'b1, 32'h600, 32'h77);
    n_checks++;
    if (bus.oIO_ADDR !== 32'h600 || bus.oIO_DATA !== 32'h77)
      $display("FAIL tmo_next_issue: addr=%h data=%h, expected 600/77", bus.oIO_ADDR, bus.oIO_DATA);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.oREQ1_VALID !== 1'b1) $display("FAIL tmo_next_ack: valid1=%b, expected 1", bus.oREQ1_VALID);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_illegal_order();
    push_exp(1'b1, 1'b1, '0);
    do_request(1, 2'b11, 1'b0, 32'h700, 32'h0);
    n_checks++;
    if (bus.oIO_REQ !== 1'b0 || bus.oREQ1_VALID !== 1'b0)
      $display("FAIL ill_first: io_req=%b valid1=%b, expected 0/0", bus.oIO_REQ, bus.oREQ1_VALID);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.oIO_REQ !== 1'b0 || bus.oREQ1_VALID !== 1'b1 || bus.oREQ1_ERROR !== 1'b1)
      $display("FAIL ill_resp: io_req=%b valid1=%b err1=%b, expected 0/1/1",
               bus.oIO_REQ, bus.oREQ1_VALID, bus.oREQ1_ERROR);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int            id;
    bit            ok;
    bit            exp_id;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] ret;
    bus.iREQ0_ORDER = 2'b10; bus.iREQ0_RW = 1'b0; bus.iREQ0_ADDR = 32'h200;
    bus.iREQ1_ORDER = 2'b10; bus.iREQ1_RW = 1'b0; bus.iREQ1_ADDR = 32'h300;
    bus.iREQ0_REQ = 1'b1; bus.iREQ1_REQ = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id = ~last_grant;
      wait_grant(id, ok);
      if (!ok) break;
      n_checks++;
      if (id !== int'(exp_id)) $display("FAIL rr_order k%0d: granted %0d, expected %0d", k, id, exp_id);
      else n_pass++;
      if (k == 3) begin bus.iREQ0_REQ = 1'b0; bus.iREQ1_REQ = 1'b0; end
      exp_addr = (id == 1) ? 32'h300 : 32'h200;
      push_exp(id[0], 1'b0, (id == 1) ? 32'h22 : 32'h11);
      n_checks++;
      if (bus.oIO_REQ !== 1'b1 || bus.oIO_ADDR !== exp_addr)
        $display("FAIL rr_issue k%0d: io_req=%b addr=%h, expected 1/%h", k, bus.oIO_REQ, bus.oIO_ADDR, exp_addr);
      else n_pass++;
      ret = (bus.oIO_ADDR == 32'h200) ? 32'h11 : 32'h22;
      @(negedge clk);
      bus.iIO_VALID = 1'b1; bus.iIO_DATA = ret;
      @(negedge clk);
      bus.iIO_VALID = 1'b0; bus.iIO_DATA = 32'h0;
      @(negedge clk);
    end
    bus.iREQ0_REQ = 1'b0; bus.iREQ1_REQ = 1'b0;
  endtask

  task automatic test_reset_mid();
    int id;
    bit ok;
    do_request(0, 2'b10, 1'b0, 32'h800, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.oIO_REQ, bus.oIO_ORDER, bus.oIO_RW, bus.oIO_ADDR, bus.oIO_DATA,
         bus.oREQ0_VALID, bus.oREQ0_ERROR, bus.oREQ0_DATA, bus.oREQ1_VALID, bus.oREQ1_ERROR, bus.oREQ1_DATA} !== '0)
      $display("FAIL rst_mid_outputs: io_req=%b addr=%h order=%b v0=%b v1=%b, expected all 0",
               bus.oIO_REQ, bus.oIO_ADDR, bus.oIO_ORDER, bus.oREQ0_VALID, bus.oREQ1_VALID);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_grant = 1'b1;
    bus.iREQ0_ORDER = 2'b00; bus.iREQ0_RW = 1'b1; bus.iREQ0_ADDR = 32'h900; bus.iREQ0_DATA = 32'h1;
    bus.iREQ1_ORDER = 2'b00; bus.iREQ1_RW = 1'b1; bus.iREQ1_ADDR = 32'hA00; bus.iREQ1_DATA = 32'h2;
    bus.iREQ0_REQ = 1'b1; bus.iREQ1_REQ = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_grant(id, ok);
      if (!ok) break;
      n_checks++;
      if (id !== k) $display("FAIL rst_mid_grant k%0d: granted %0d, expected %0d", k, id, k);
      else n_pass++;
      push_exp(id[0], 1'b0, '0);
      if (id == 0) bus.iREQ0_REQ = 1'b0;
      else         bus.iREQ1_REQ = 1'b0;
      repeat (2) @(negedge clk);
    end
    bus.iREQ0_REQ = 1'b0; bus.iREQ1_REQ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    @(negedge clk);
    test_write_basic();
    test_io_stall();
    test_timeout();
    test_illegal_order();
    test_round_robin();
    test_reset_mid();
    repeat (5) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
